// File: rtl/maxpool_pkg.sv
// Shared constants and state encoding for the max-pool result path.
// Default sizes are also used by the pooled-feature writeback.
package maxpool_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_WIN     = 4;
    localparam int DEF_NUM_WIN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Counter width for a count of n, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_window_ctrl_cmp.sv
// pool_max_cmp: running-maximum register with a signed comparator.
// take is high when din should replace the held maximum.
module pool_max_cmp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          clr_load,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] max_q,
    output logic          take
);

    // Strict greater-than so ties keep the held value
    assign take = clr_load | ($signed(din) > $signed(max_q));

    // Load the first element of a window, then keep the larger value
    always_ff @(posedge clk) begin
        if (master_rst) begin
            max_q <= '0;
        end else if (en && take) begin
            max_q <= din;
        end
    end

endmodule

// File: rtl/maxpool_window_ctrl.sv
// maxpool_window_ctrl: per-window running max with valid/ready output.
// Build option MAXPOOL_RELU_EN clamps negative pooled results to zero.
module maxpool_window_ctrl
    import maxpool_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int WIN     = DEF_WIN,
    parameter int NUM_WIN = DEF_NUM_WIN
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int EW = cnt_w(WIN);
    localparam int NW = cnt_w(NUM_WIN);
    localparam logic [EW-1:0] ELEM_LAST = EW'(WIN - 1);
    localparam logic [NW-1:0] WIN_LAST  = NW'(NUM_WIN - 1);

    state_t          state;
    logic [EW-1:0]   elem_cnt;
    logic [NW-1:0]   win_cnt;
    logic            accept;
    logic            clr_load;
    logic            take;
    logic [DW-1:0]   max_q;
    logic [DW-1:0]   max_new;
    logic [DW-1:0]   pooled;

    assign accept   = in_valid & in_ready;
    assign clr_load = (elem_cnt == '0);

    pool_max_cmp #(.DW(DW)) u_cmp (
        .clk        (clk),
        .master_rst (master_rst),
        .clr_load   (clr_load),
        .en         (accept),
        .din        (in_data),
        .max_q      (max_q),
        .take       (take)
    );

    // Maximum including the element accepted this cycle, plus optional ReLU
    always_comb begin
        max_new = take ? in_data : max_q;
`ifdef MAXPOOL_RELU_EN
        pooled  = max_new[DW-1] ? '0 : max_new;
`else
        pooled  = max_new;
`endif
    end

    // Window/frame sequencing with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (master_rst) begin
            state     <= ST_IDLE;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACCUM;
                        elem_cnt <= '0;
                        win_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (elem_cnt == ELEM_LAST) begin
                            out_data  <= pooled;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            elem_cnt  <= '0;
                            state     <= ST_EMIT;
                        end else begin
                            elem_cnt <= elem_cnt + EW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            win_cnt  <= win_cnt + NW'(1);
                            in_ready <= 1'b1;
                            state    <= ST_ACCUM;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Scoreboard bench for maxpool_window_ctrl: a WIN=4/NUM_WIN=2 instance
// and a WIN=1/NUM_WIN=3 instance, each with its own monitor.
module tb_maxpool_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- instance A: WIN=4, NUM_WIN=2 ----------------
    logic        rst_a = 1'b1, start_a = 1'b0, iv_a = 1'b0, or_a = 1'b1;
    logic [31:0] id_a = '0;
    logic        ir_a, ov_a, busy_a, done_a;
    logic [31:0] od_a;

    maxpool_window_ctrl #(.DW(32), .WIN(4), .NUM_WIN(2)) u_dut_a (
        .clk(clk), .master_rst(rst_a), .start(start_a),
        .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(or_a),
        .busy(busy_a), .done(done_a)
    );

    // ---------------- instance B: WIN=1, NUM_WIN=3 ----------------
    logic        rst_b = 1'b1, start_b = 1'b0, iv_b = 1'b0, or_b = 1'b1;
    logic [31:0] id_b = '0;
    logic        ir_b, ov_b, busy_b, done_b;
    logic [31:0] od_b;

    maxpool_window_ctrl #(.DW(32), .WIN(1), .NUM_WIN(3)) u_dut_b (
        .clk(clk), .master_rst(rst_b), .start(start_b),
        .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(or_b),
        .busy(busy_b), .done(done_b)
    );

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s", nm);
    endtask

    // Reference: pooled value is the signed max, optionally clamped at zero
    function automatic logic [31:0] post(input int m);
`ifdef MAXPOOL_RELU_EN
        return (m < 0) ? 32'd0 : 32'(m);
`else
        return 32'(m);
`endif
    endfunction

    function automatic logic [31:0] ref_pool(input int a, input int b, input int c, input int d);
        int vals[4];
        int m;
        vals = '{a, b, c, d};
        m = vals[0];
        foreach (vals[i]) if (vals[i] > m) m = vals[i];
        return post(m);
    endfunction

    function automatic int rv();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 0;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor A ----------------
    int          hs_a = 0;
    bit          pend_a = 1'b0, stall_a = 1'b0;
    logic [31:0] prev_a;

    initial forever begin
        @(negedge clk);
        if (rst_a) begin
            q_a.delete();
            hs_a = 0; pend_a = 1'b0; stall_a = 1'b0;
        end else begin
            if (pend_a || done_a) chk("done_a", 32'(done_a), 32'(pend_a));
            pend_a = 1'b0;
            if (stall_a) begin
                chk("hold_valid_a", 32'(ov_a), 32'd1);
                chk("hold_data_a", od_a, prev_a);
                chk("hold_in_ready_a", 32'(ir_a), 32'd0);
            end
            if (ov_a && or_a) begin
                if (q_a.size() == 0) flag_fail("unexpected_out_a");
                else chk("out_a", od_a, q_a.pop_front());
                hs_a++;
                if (hs_a == 2) begin hs_a = 0; pend_a = 1'b1; end
            end
            stall_a = ov_a && !or_a;
            prev_a  = od_a;
        end
    end

    // ---------------- monitor B ----------------
    int  hs_b = 0;
    bit  pend_b = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst_b) begin
            q_b.delete();
            hs_b = 0; pend_b = 1'b0;
        end else begin
            if (pend_b || done_b) chk("done_b", 32'(done_b), 32'(pend_b));
            pend_b = 1'b0;
            if (ov_b && or_b) begin
                if (q_b.size() == 0) flag_fail("unexpected_out_b");
                else chk("out_b", od_b, q_b.pop_front());
                hs_b++;
                if (hs_b == 3) begin hs_b = 0; pend_b = 1'b1; end
            end
        end
    end

    // ---------------- out_ready drivers ----------------
    int or_mode = 0;
    int hold_cnt = 0;
    int or_mode_b = 0;

    initial forever begin
        step();
        case (or_mode)
            1: or_a = ($urandom_range(0, 2) != 0);
            2: begin
                if (ov_a) hold_cnt++;
                or_a = (hold_cnt > 10);
            end
            default: or_a = 1'b1;
        endcase
        or_b = (or_mode_b == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
    end

    // ---------------- drivers ----------------
    int fr_a[8];

    task automatic send_a(input int v);
        bit ok;
        int n;
        n = 0;
        iv_a = 1'b1;
        id_a = 32'(v);
        do begin
            ok = ir_a;
            step();
            n++;
        end while (!ok && n < 200);
        if (!ok) flag_fail("send_timeout_a");
        iv_a = 1'b0;
        id_a = 32'(rv());
    endtask

    task automatic send_b(input int v);
        bit ok;
        int n;
        n = 0;
        iv_b = 1'b1;
        id_b = 32'(v);
        do begin
            ok = ir_b;
            step();
            n++;
        end while (!ok && n < 200);
        if (!ok) flag_fail("send_timeout_b");
        iv_b = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while ((q_a.size() != 0 || busy_a) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) flag_fail("drain_timeout_a");
        step();
        step();
    endtask

    task automatic run_frame_a(input bit gaps, input bit noise);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("busy_after_start_a", 32'(busy_a), 32'd1);
        chk("in_ready_after_start_a", 32'(ir_a), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    if (noise && $urandom_range(0, 1) == 1) start_a = 1'b1;
                    step();
                    start_a = 1'b0;
                end
            end
            send_a(fr_a[i]);
            if (i % 4 == 3)
                q_a.push_back(ref_pool(fr_a[i-3], fr_a[i-2], fr_a[i-1], fr_a[i]));
        end
        wait_idle_a();
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_out_valid"}, 32'(ov_a), 32'd0);
        chk({tag, "_out_data"}, od_a, 32'd0);
        chk({tag, "_in_ready"}, 32'(ir_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
    endtask

    task automatic run_frame_b(input int v0, input int v1, input int v2);
        int vals[3];
        vals = '{v0, v1, v2};
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        foreach (vals[i]) begin
            send_b(vals[i]);
            q_b.push_back(post(vals[i]));
        end
        for (int n = 0; n < 300 && (q_b.size() != 0 || busy_b); n++) step();
        if (q_b.size() != 0 || busy_b) flag_fail("drain_timeout_b");
        step();
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check_reset_a("reset_a");
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Directed windows: max 9 then -1
        fr_a = '{3, -7, 9, 2, -1, -5, -3, -8};
        run_frame_a(1'b0, 1'b0);

        // Signed extremes in one window
        fr_a = '{32'h7FFF_FFFF, 32'h8000_0000, 0, 1, rv(), rv(), rv(), rv()};
        run_frame_a(1'b0, 1'b0);

        // First result held for ten cycles of back-pressure
        foreach (fr_a[i]) fr_a[i] = rv();
        hold_cnt = 0;
        or_mode = 2;
        run_frame_a(1'b0, 1'b0);
        or_mode = 0;

        // Reset after two elements, then a clean frame
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        send_a(1000);
        send_a(2000);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check_reset_a("midframe_reset_a");
        step();
        fr_a = '{4, 4, 4, 4, -20, -10, -30, -40};
        run_frame_a(1'b0, 1'b0);

        // Same frame with gaps and stray start pulses, then gap-free
        foreach (fr_a[i]) fr_a[i] = rv();
        run_frame_a(1'b1, 1'b1);
        run_frame_a(1'b0, 1'b0);

        // Random frames under random back-pressure
        or_mode = 1;
        repeat (8) begin
            foreach (fr_a[i]) fr_a[i] = rv();
            run_frame_a(1'b1, 1'b1);
        end
        or_mode = 0;
        step();
        chk("drain_a", 32'(q_a.size()), 32'd0);

        // WIN=1 instance: elements pass through unchanged
        run_frame_b(5, -2, 8);
        or_mode_b = 1;
        repeat (3) run_frame_b(rv(), rv(), rv());
        or_mode_b = 0;
        step();
        chk("drain_b", 32'(q_b.size()), 32'd0);
        chk("idle_busy_b", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
